// File: rtl/excp_commit_arb.sv
// Commit-stage exception/interrupt/eret arbiter feeding cp0 and the fetch redirect port.
// Optional perf counters are enabled by defining EXC_ARB_PERF_EN.
module excp_commit_arb #(
  parameter int EXC_W     = 8,
  parameter int FLUSH_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            c_valid,
  input  logic [1:0][31:0]      c_pc,
  input  logic [1:0]            c_branch,
  input  logic [1:0][EXC_W-1:0] c_excp,
  input  logic [1:0]            c_eret,
  output logic                  commit_ready,
  output logic [1:0]            retire,
  input  logic                  cp0_is_int,
  input  logic [31:0]           cp0_entrance,
  input  logic [31:0]           cp0_epc,
  output logic                  exc_valid,
  output logic [31:0]           exc_pc,
  output logic [EXC_W-1:0]      exc_etype,
  output logic                  exc_slot,
  output logic                  eret_valid,
  output logic                  inter_valid,
  output logic [31:0]           int_pc,
  output logic                  int_slot,
  output logic                  redir_valid,
  output logic [31:0]           redir_pc,
  input  logic                  redir_ready,
  output logic                  flush
`ifdef EXC_ARB_PERF_EN
  ,
  output logic [31:0]           perf_exc,
  output logic [31:0]           perf_int,
  output logic [31:0]           perf_eret
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REDIR = 2'd1, FLUSH = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        last_br_q, last_br_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic event_s, slot0_s, slot1_s, trap0_s, trap1_s, eret0_s, eret1_s;

  assign slot0_s = last_br_q;
  assign slot1_s = c_branch[0] && c_valid[0];
  assign trap0_s = c_valid[0] && (|c_excp[0]);
  assign trap1_s = c_valid[1] && (|c_excp[1]);
  assign eret0_s = c_valid[0] && c_eret[0];
  assign eret1_s = c_valid[1] && c_eret[1];

  // Event arbitration, cp0 strobes and FSM next state
  always_comb begin
    state_d     = state_q;
    last_br_d   = last_br_q;
    cnt_d       = cnt_q;
    redir_pc_d  = redir_pc_q;
    event_s     = 1'b0;
    retire      = 2'b00;
    exc_valid   = 1'b0;
    exc_pc      = 32'h0;
    exc_etype   = '0;
    exc_slot    = 1'b0;
    eret_valid  = 1'b0;
    inter_valid = 1'b0;
    int_pc      = 32'h0;
    int_slot    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cp0_is_int && (|c_valid)) begin
          inter_valid = 1'b1;
          event_s     = 1'b1;
          redir_pc_d  = cp0_entrance;
          if (c_valid[0]) begin
            int_pc   = c_pc[0];
            int_slot = slot0_s;
          end else begin
            int_pc   = c_pc[1];
            int_slot = slot1_s;
          end
        end else if (trap0_s) begin
          exc_valid  = 1'b1;
          exc_pc     = c_pc[0];
          exc_etype  = c_excp[0];
          exc_slot   = slot0_s;
          event_s    = 1'b1;
          redir_pc_d = cp0_entrance;
        end else if (eret0_s) begin
          eret_valid = 1'b1;
          retire     = 2'b01;
          event_s    = 1'b1;
          redir_pc_d = cp0_epc;
        end else if (trap1_s) begin
          exc_valid  = 1'b1;
          exc_pc     = c_pc[1];
          exc_etype  = c_excp[1];
          exc_slot   = slot1_s;
          retire     = {1'b0, c_valid[0]};
          event_s    = 1'b1;
          redir_pc_d = cp0_entrance;
        end else if (eret1_s) begin
          eret_valid = 1'b1;
          retire     = {1'b0, c_valid[0]};
          event_s    = 1'b1;
          redir_pc_d = cp0_epc;
        end else begin
          retire = c_valid;
        end
        // The delay-slot tracker follows the youngest lane that actually retired
        if (event_s) begin
          last_br_d = 1'b0;
          state_d   = REDIR;
        end else if (retire[1]) begin
          last_br_d = c_branch[1];
        end else if (retire[0]) begin
          last_br_d = c_branch[0];
        end else begin
          last_br_d = last_br_q;
        end
      end
      REDIR: begin
        if (redir_ready) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYC - 1);
        end else begin
          state_d = REDIR;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit_ready = (state_q == IDLE);
  assign redir_valid  = (state_q == REDIR);
  assign redir_pc     = redir_pc_q;
  assign flush        = event_s || (state_q != IDLE);

  // State, delay-slot tracker, flush counter and redirect target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_br_q  <= 1'b0;
      cnt_q      <= 4'd0;
      redir_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_br_q  <= last_br_d;
      cnt_q      <= cnt_d;
      redir_pc_q <= redir_pc_d;
    end
  end

`ifdef EXC_ARB_PERF_EN
  // Taken-event counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_exc  <= 32'h0;
      perf_int  <= 32'h0;
      perf_eret <= 32'h0;
    end else begin
      perf_exc  <= perf_exc + {31'h0, exc_valid};
      perf_int  <= perf_int + {31'h0, inter_valid};
      perf_eret <= perf_eret + {31'h0, eret_valid};
    end
  end
`endif

endmodule

// File: tb/tb_excp_commit_arb.sv
// Directed self-checking bench for excp_commit_arb (default build, FLUSH_CYC=2).
module tb_excp_commit_arb;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       c_valid, c_branch, c_eret, retire;
  logic [1:0][31:0] c_pc;
  logic [1:0][7:0]  c_excp;
  logic             commit_ready, cp0_is_int, exc_valid, exc_slot, eret_valid;
  logic             inter_valid, int_slot, redir_valid, redir_ready, flush;
  logic [31:0]      cp0_entrance, cp0_epc, exc_pc, int_pc, redir_pc;
  logic [7:0]       exc_etype;
`ifdef EXC_ARB_PERF_EN
  logic [31:0]      perf_exc, perf_int, perf_eret;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  excp_commit_arb #(.EXC_W(8), .FLUSH_CYC(2)) dut (
    .clk(clk), .reset(reset), .c_valid(c_valid), .c_pc(c_pc), .c_branch(c_branch),
    .c_excp(c_excp), .c_eret(c_eret), .commit_ready(commit_ready), .retire(retire),
    .cp0_is_int(cp0_is_int), .cp0_entrance(cp0_entrance), .cp0_epc(cp0_epc),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_etype(exc_etype), .exc_slot(exc_slot),
    .eret_valid(eret_valid), .inter_valid(inter_valid), .int_pc(int_pc), .int_slot(int_slot),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready), .flush(flush)
`ifdef EXC_ARB_PERF_EN
    , .perf_exc(perf_exc), .perf_int(perf_int), .perf_eret(perf_eret)
`endif
  );

  task automatic clear_inputs();
    c_valid = 2'b00; c_branch = 2'b00; c_eret = 2'b00; cp0_is_int = 1'b0;
    c_pc = '0; c_excp = '0; redir_ready = 1'b0;
  endtask

  // Drives idle inputs from the cycle after an event and walks REDIR -> FLUSH -> IDLE.
  task automatic finish_redirect(input logic [31:0] exp_pc, input string tag);
    @(negedge clk); clear_inputs(); cp0_entrance = 32'h1111_2222; cp0_epc = 32'h3333_4444; #1;
    n_chk++; if (redir_valid !== 1'b1) begin n_fail++; $display("FAIL %s redir_valid: got %b want 1", tag, redir_valid); end
    n_chk++; if (redir_pc !== exp_pc) begin n_fail++; $display("FAIL %s redir_pc: got %h want %h", tag, redir_pc, exp_pc); end
    n_chk++; if (commit_ready !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL %s redir_state: got ready=%b flush=%b want 0/1", tag, commit_ready, flush); end
    redir_ready = 1'b1;
    @(negedge clk); redir_ready = 1'b0; #1;
    n_chk++; if (redir_valid !== 1'b0 || flush !== 1'b1 || commit_ready !== 1'b0) begin n_fail++; $display("FAIL %s flush1: got rv=%b flush=%b ready=%b want 0/1/0", tag, redir_valid, flush, commit_ready); end
    @(negedge clk); #1;
    n_chk++; if (commit_ready !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL %s flush2: got ready=%b flush=%b want 0/1", tag, commit_ready, flush); end
    @(negedge clk); #1;
    n_chk++; if (commit_ready !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL %s back_idle: got ready=%b flush=%b want 1/0", tag, commit_ready, flush); end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0; #1;
    n_chk++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL reset commit_ready: got %b want 1", commit_ready); end
    n_chk++; if (redir_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL reset redir/flush: got %b/%b want 0/0", redir_valid, flush); end
    n_chk++; if (redir_pc !== 32'h0 || retire !== 2'b00) begin n_fail++; $display("FAIL reset pc/retire: got %h/%b want 0/00", redir_pc, retire); end
  endtask

  task automatic test_clean_retire();
    @(negedge clk); clear_inputs(); c_valid = 2'b11; c_pc[0] = 32'h40; c_pc[1] = 32'h44; #1;
    n_chk++; if (retire !== 2'b11) begin n_fail++; $display("FAIL clean retire: got %b want 11", retire); end
    n_chk++; if ({exc_valid, eret_valid, inter_valid, flush} !== 4'b0000) begin n_fail++; $display("FAIL clean strobes: got %b want 0000", {exc_valid, eret_valid, inter_valid, flush}); end
    @(negedge clk); #1;
    n_chk++; if (commit_ready !== 1'b1 || redir_valid !== 1'b0) begin n_fail++; $display("FAIL clean ready: got %b/%b want 1/0", commit_ready, redir_valid); end
  endtask

  task automatic test_lane0_exc();
    @(negedge clk); clear_inputs(); cp0_entrance = 32'hbfc0_0380;
    c_valid = 2'b11; c_pc[0] = 32'h8000_1000; c_pc[1] = 32'h8000_1004; c_excp[0] = 8'h04; #1;
    n_chk++; if (exc_valid !== 1'b1 || exc_pc !== 32'h8000_1000) begin n_fail++; $display("FAIL l0exc strobe: got %b %h want 1 80001000", exc_valid, exc_pc); end
    n_chk++; if (exc_etype !== 8'h04 || exc_slot !== 1'b0) begin n_fail++; $display("FAIL l0exc etype/slot: got %h/%b want 04/0", exc_etype, exc_slot); end
    n_chk++; if (retire !== 2'b00 || flush !== 1'b1) begin n_fail++; $display("FAIL l0exc retire/flush: got %b/%b want 00/1", retire, flush); end
    finish_redirect(32'hbfc0_0380, "l0exc");
  endtask

  task automatic test_ignored_in_redir();
    @(negedge clk); clear_inputs(); cp0_entrance = 32'hbfc0_0380; c_valid = 2'b01; c_excp[0] = 8'h80; #1;
    @(negedge clk); clear_inputs(); c_valid = 2'b11; c_excp[1] = 8'h01; c_eret = 2'b01; cp0_is_int = 1'b1; #1;
    n_chk++; if ({retire, exc_valid, eret_valid, inter_valid} !== 5'b00000) begin n_fail++; $display("FAIL redir_ignore: got %b want 00000", {retire, exc_valid, eret_valid, inter_valid}); end
    @(negedge clk); clear_inputs(); redir_ready = 1'b1;
    @(negedge clk); redir_ready = 1'b0;
    @(negedge clk); c_valid = 2'b11; c_excp[0] = 8'h02; #1;
    n_chk++; if ({retire, exc_valid} !== 3'b000 || commit_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ignore: got %b ready=%b want 000 0", {retire, exc_valid}, commit_ready); end
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL ignore_idle: got %b want 1", commit_ready); end
  endtask

  task automatic test_lane1_exc_slot();
    @(negedge clk); clear_inputs(); cp0_entrance = 32'hbfc0_0380;
    c_valid = 2'b11; c_branch = 2'b01; c_pc[0] = 32'h100; c_pc[1] = 32'h104; c_excp[1] = 8'h01; #1;
    n_chk++; if (retire !== 2'b01) begin n_fail++; $display("FAIL l1exc retire: got %b want 01", retire); end
    n_chk++; if (exc_valid !== 1'b1 || exc_pc !== 32'h104 || exc_etype !== 8'h01) begin n_fail++; $display("FAIL l1exc strobe: got %b %h %h want 1 104 01", exc_valid, exc_pc, exc_etype); end
    n_chk++; if (exc_slot !== 1'b1) begin n_fail++; $display("FAIL l1exc slot: got %b want 1", exc_slot); end
    finish_redirect(32'hbfc0_0380, "l1exc");
  endtask

  task automatic test_slot0_last_br();
    @(negedge clk); clear_inputs(); c_valid = 2'b11; c_branch = 2'b10; #1;
    @(negedge clk); clear_inputs(); cp0_entrance = 32'hbfc0_0200; c_valid = 2'b01; c_pc[0] = 32'h308; c_excp[0] = 8'h10; #1;
    n_chk++; if (exc_valid !== 1'b1 || exc_slot !== 1'b1) begin n_fail++; $display("FAIL slot0 exc: got %b/%b want 1/1", exc_valid, exc_slot); end
    finish_redirect(32'hbfc0_0200, "slot0");
    @(negedge clk); clear_inputs(); cp0_entrance = 32'hbfc0_0300; c_valid = 2'b01; c_excp[0] = 8'h20; #1;
    n_chk++; if (exc_slot !== 1'b0) begin n_fail++; $display("FAIL slot0 cleared: got %b want 0", exc_slot); end
    finish_redirect(32'hbfc0_0300, "slot0b");
  endtask

  task automatic test_interrupt();
    @(negedge clk); clear_inputs(); c_valid = 2'b01; c_branch = 2'b01; #1;
    @(negedge clk); clear_inputs(); cp0_entrance = 32'hbfc0_0380; cp0_is_int = 1'b1;
    c_valid = 2'b10; c_pc[1] = 32'h200; c_excp[1] = 8'h08; #1;
    n_chk++; if (inter_valid !== 1'b1 || int_pc !== 32'h200) begin n_fail++; $display("FAIL int strobe: got %b %h want 1 200", inter_valid, int_pc); end
    n_chk++; if (int_slot !== 1'b0 || retire !== 2'b00 || exc_valid !== 1'b0) begin n_fail++; $display("FAIL int slot/retire: got %b %b %b want 0 00 0", int_slot, retire, exc_valid); end
    finish_redirect(32'hbfc0_0380, "int");
  endtask

  task automatic test_eret_backpressure();
    @(negedge clk); clear_inputs(); cp0_epc = 32'h8000_2000; c_valid = 2'b11; c_eret = 2'b01; c_excp[1] = 8'h01; #1;
    n_chk++; if (eret_valid !== 1'b1 || retire !== 2'b01 || exc_valid !== 1'b0) begin n_fail++; $display("FAIL eret strobe: got %b %b %b want 1 01 0", eret_valid, retire, exc_valid); end
    @(negedge clk); clear_inputs(); cp0_epc = 32'h0bad_0bad;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_2000) begin n_fail++; $display("FAIL eret hold%0d: got %b %h want 1 80002000", i, redir_valid, redir_pc); end
      @(negedge clk);
    end
    redir_ready = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL eret one_accept: got %b want 0", redir_valid); end
    @(negedge clk); redir_ready = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL eret idle: got %b want 1", commit_ready); end
  endtask

  task automatic test_reset_mid_redir();
    @(negedge clk); clear_inputs(); c_valid = 2'b01; c_excp[0] = 8'h01; #1;
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (redir_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre: got %b want 1", redir_valid); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    n_chk++; if (redir_valid !== 1'b0 || flush !== 1'b0 || commit_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid: got rv=%b flush=%b ready=%b want 0/0/1", redir_valid, flush, commit_ready); end
  endtask

  initial begin
    reset = 1'b1; clear_inputs(); cp0_entrance = 32'h0; cp0_epc = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_clean_retire();
    test_lane0_exc();
    test_ignored_in_redir();
    test_lane1_exc_slot();
    test_slot0_last_br();
    test_interrupt();
    test_eret_backpressure();
    test_reset_mid_redir();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
